// File: rtl/key_schedule_192_seq.sv
// AES-192 key-schedule sequencer: expands a 192-bit key six words at a time and streams
// the 13 resulting 128-bit round keys over a valid/ready port.
module key_schedule_192_seq #(
    parameter int NR_KEYS = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [191:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, EVEN, ODD_A, ODD_B} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] LAST_INDEX = 4'(NR_KEYS - 1);
    localparam logic [3:0] LAST_CHUNK = 4'd8;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] pos;
        pos = 11'd2047 - {b, 3'b000};
        return SBOX[pos -: 8];
    endfunction

    state_t         state_reg, state_next;
    logic [191:0]   chunk_reg, chunk_next;
    logic [63:0]    left_reg, left_next;
    logic [3:0]     c_reg, c_next;
    logic [3:0]     idx_reg, idx_next;
    logic           done_reg, done_next;

    logic [31:0]    w [6];
    logic [31:0]    rot_word;
    logic [31:0]    sub_rot;
    logic [31:0]    rcon;
    logic [31:0]    acc;
    logic [191:0]   exp_chunk;
    logic [127:0]   rk_word;
    logic           valid_c;
    logic           handshake;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_words
            assign w[gi] = chunk_reg[191 - 32*gi -: 32];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_rot[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
        end
    endgenerate

    assign rot_word = {w[5][23:0], w[5][31:24]};
    // c_reg holds the index of the current chunk, so the next chunk uses rc = 2^c
    assign rcon     = {8'h01 << c_reg[2:0], 24'h0};

    always_comb begin
        exp_chunk = '0;
        acc = w[0] ^ sub_rot ^ rcon;
        exp_chunk[191:160] = acc;
        for (int i = 1; i < 6; i++) begin
            acc = acc ^ w[i];
            exp_chunk[191 - 32*i -: 32] = acc;
        end
    end

    always_comb begin
        state_next = state_reg;
        chunk_next = chunk_reg;
        left_next  = left_reg;
        c_next     = c_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;
        valid_c    = 1'b0;
        rk_word    = '0;
        handshake  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (key_load) begin
                    chunk_next = key_in;
                    c_next     = 4'd0;
                    idx_next   = 4'd0;
                    state_next = EVEN;
                end
            end
            EVEN: begin
                valid_c   = 1'b1;
                rk_word   = chunk_reg[191:64];
                handshake = rk_ready;
                if (handshake) begin
                    left_next = chunk_reg[63:0];
                    if (c_reg == LAST_CHUNK) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        chunk_next = exp_chunk;
                        c_next     = c_reg + 4'd1;
                        state_next = ODD_A;
                    end
                end
            end
            ODD_A: begin
                valid_c   = 1'b1;
                rk_word   = {left_reg, chunk_reg[191:128]};
                handshake = rk_ready;
                if (handshake) begin
                    state_next = ODD_B;
                end
            end
            ODD_B: begin
                valid_c   = 1'b1;
                rk_word   = chunk_reg[127:0];
                handshake = rk_ready;
                if (handshake) begin
                    chunk_next = exp_chunk;
                    c_next     = c_reg + 4'd1;
                    state_next = EVEN;
                end
            end
            default: state_next = IDLE;
        endcase

        // Index saturates on the final key so it stays within 0..12
        if (handshake && idx_reg != LAST_INDEX) begin
            idx_next = idx_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            chunk_reg <= '0;
            left_reg  <= '0;
            c_reg     <= '0;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            chunk_reg <= chunk_next;
            left_reg  <= left_next;
            c_reg     <= c_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
        end
    end

    assign rk_valid = valid_c;
    assign busy     = valid_c;
    assign rk_out   = rk_word;
    assign rk_index = idx_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_key_schedule_192_seq.sv
// Bench for key_schedule_192_seq: known-answer table plus randomized keys and
// handshake patterns checked against a word-level AES-192 schedule model.
module tb_key_schedule_192_seq;

    logic         clk;
    logic         reset;
    logic [191:0] key_in;
    logic         key_load;
    logic         busy;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         rk_valid;
    logic         rk_ready;
    logic         done;

    key_schedule_192_seq dut (
        .clk      (clk),
        .reset    (reset),
        .key_in   (key_in),
        .key_load (key_load),
        .busy     (busy),
        .rk_out   (rk_out),
        .rk_index (rk_index),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [13];
    logic [127:0] got_rk [13];

    localparam logic [191:0] KEY_T1   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [191:0] KEY_ZERO = 192'h0;

    typedef struct {
        logic [191:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box derived from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_model(input logic [191:0] key);
        logic [31:0] wm [52];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 6; i++) wm[i] = key[191 - 32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = wm[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            wm[i] = wm[i-6] ^ t;
        end
        for (int r = 0; r < 13; r++) exp_rk[r] = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
    endtask

    function automatic logic [191:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a sample point with the DUT idle; returns at the sample point of the done cycle
    task automatic run_key(input logic [191:0] key, input bit random_ready, input bit mess_load);
        int n = 0;
        int cycles = 0;
        bit ready;
        logic [127:0] prev_out;
        logic [3:0]   prev_idx;
        build_model(key);
        key_in = key;
        key_load = 1'b1;
        rk_ready = 1'b0;
        @(posedge clk); #1;
        key_load = 1'b0;
        chk("rk0_latency_valid", rk_valid, 1);
        while (n < 13 && cycles < 400) begin
            chk("stream_valid", rk_valid, 1);
            chk("stream_busy", busy, 1);
            chk("stream_no_done", done, 0);
            ready = random_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (ready) begin
                chk($sformatf("rk%0d_index", n), rk_index, 128'(n));
                chk($sformatf("rk%0d_value", n), rk_out, exp_rk[n]);
                got_rk[n] = rk_out;
                $display("hs key=%h idx=%0d rk=%h", key[191:160], rk_index, rk_out);
                n++;
            end
            prev_out = rk_out;
            prev_idx = rk_index;
            rk_ready = ready;
            if (mess_load) begin
                key_load = 1'($urandom_range(0, 1));
                key_in = rand_key();
            end
            @(posedge clk); #1;
            cycles++;
            if (!ready) begin
                chk("stall_rk_out", rk_out, prev_out);
                chk("stall_rk_index", rk_index, prev_idx);
            end
        end
        chk("handshake_count", 128'(n), 128'd13);
        rk_ready = 1'b0;
        key_load = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_valid_low", rk_valid, 0);
        chk("done_busy_low", busy, 0);
        if (!random_ready) chk("consecutive_cycles", 128'(cycles), 128'd13);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{KEY_T1, 0, 128'h8e73b0f7da0e6452c810f32b809079e5};
        vecs[1] = '{KEY_T1, 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vecs[2] = '{KEY_T1, 2, 128'hec12068e6c827f6b0e7a95b95c56fec2};
        vecs[3] = '{KEY_T1, 12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[4] = '{KEY_ZERO, 0, 128'h0};
        vecs[5] = '{KEY_ZERO, 1, 128'h00000000000000006263636362636363};
        vecs[6] = '{KEY_ZERO, 2, 128'h62636363626363636263636362636363};

        clk = 1'b0;
        reset = 1'b1;
        key_in = '0;
        key_load = 1'b0;
        rk_ready = 1'b0;
        build_sbox();

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_valid", rk_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rk_out", rk_out, 0);
        chk("reset_rk_index", rk_index, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Known-answer table (also exercises back-to-back loads between keys)
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || vecs[i].key != vecs[i-1].key) run_key(vecs[i].key, 1'b0, 1'b0);
            chk($sformatf("vec%0d_rk%0d", i, vecs[i].idx), got_rk[vecs[i].idx], vecs[i].rk);
        end

        // Stalls with pseudo-random ready, then done must not repeat
        @(posedge clk); #1;
        run_key(KEY_T1, 1'b1, 1'b0);
        chk("t2_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
        @(posedge clk); #1;
        chk("t2_done_once", done, 0);

        // Loads while busy are ignored
        run_key(KEY_T1, 1'b1, 1'b1);
        chk("t3_rk1", got_rk[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);

        // Done cycle immediately reloading an all-zero key
        run_key(KEY_T1, 1'b0, 1'b0);
        run_key(KEY_ZERO, 1'b0, 1'b0);
        chk("t5_rk0", got_rk[0], 128'h0);
        chk("t5_rk1", got_rk[1], 128'h00000000000000006263636362636363);

        // Reset after the rk5 handshake
        @(posedge clk); #1;
        key_in = KEY_T1;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        rk_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("t4_pre_index", rk_index, 6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rk_ready = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_valid", rk_valid, 0);
        chk("t4_rk_out", rk_out, 0);
        chk("t4_rk_index", rk_index, 0);
        chk("t4_done", done, 0);
        @(posedge clk); #1;
        chk("t4_no_done_later", done, 0);
        run_key(KEY_T1, 1'b0, 1'b0);

        // Reset and load in the same cycle
        @(posedge clk); #1;
        reset = 1'b1;
        key_load = 1'b1;
        key_in = KEY_T1;
        @(posedge clk); #1;
        reset = 1'b0;
        key_load = 1'b0;
        chk("t6_valid", rk_valid, 0);
        @(posedge clk); #1;
        chk("t6_valid_after", rk_valid, 0);
        chk("t6_busy_after", busy, 0);

        // Random keys with random backpressure against the model
        for (int k = 0; k < 4; k++) begin
            run_key(rand_key(), 1'b1, 1'b0);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
